ipsxe_fft_frame_sched: RTL

//  Shares one FFT core input stream between NUM_CH frame requesters. Round-robin arbitration per frame.

---
 rtl/ipsxe_fft_frame_sched.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ipsxe_fft_frame_sched.sv
// rtl/ipsxe_fft_frame_sched.sv - round-robin frame scheduler feeding one FFT core from NUM_CH sources
//
// Ports:
//   i_clk, srstn            clock, asynchronous active-low reset
//   i_aclken                clock enable qualifying every state update
//   i_req_tvalid/tdata/tlast/dir, o_req_tready   per-channel sample streams
//   o_fft_tvalid/tdata/tlast, i_fft_tready       core xn stream
//   o_cfg_tvalid/tdata                           core cfg stream (direction, one beat per frame)
//   i_xk_tvalid/tlast, o_xk_ch                   core output frame boundary and owning channel
//   o_frm_err, i_err_clr                         sticky length/underflow error and its clear
//   o_busy                                       frame in flight or output frames outstanding
module ipsxe_fft_frame_sched #(
    parameter int NUM_CH       = 2,
    parameter int CH_W         = 1,
    parameter int DW           = 32,
    parameter int LOG2_FFT_LEN = 11,
    parameter int MAX_OUT      = 4
) (
    input  logic                 i_clk,
    input  logic                 srstn,
    input  logic                 i_aclken,
    input  logic [NUM_CH-1:0]    i_req_tvalid,
    input  logic [NUM_CH*DW-1:0] i_req_tdata,
    input  logic [NUM_CH-1:0]    i_req_tlast,
    input  logic [NUM_CH-1:0]    i_req_dir,
    output logic [NUM_CH-1:0]    o_req_tready,
    output logic                 o_fft_tvalid,
    output logic [DW-1:0]        o_fft_tdata,
    output logic                 o_fft_tlast,
    input  logic                 i_fft_tready,
    output logic                 o_cfg_tvalid,
    output logic                 o_cfg_tdata,
    input  logic                 i_xk_tvalid,
    input  logic                 i_xk_tlast,
    output logic [CH_W-1:0]      o_xk_ch,
    output logic                 o_frm_err,
    input  logic                 i_err_clr,
    output logic                 o_busy
);

    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [LOG2_FFT_LEN-1:0] LAST_BEAT = '1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(MAX_OUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CFG  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [CH_W-1:0]         gnt_ch;
    logic                    gnt_dir;
    logic [CH_W-1:0]         rr_ptr;
    logic [LOG2_FFT_LEN-1:0] cnt;

    logic [CH_W-1:0]         tag_mem [MAX_OUT];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [PW:0]             tag_cnt;
    logic [CH_W-1:0]         xk_ch_q;
    logic                    err_q;

    logic [CH_W-1:0]         pick_ch, cand;
    logic                    pick_vld;
    logic                    grant, beat_acc, beat_last, len_err;
    logic                    pop_req, pop_ok, err_set;
    logic [PW:0]             tag_cnt_nxt, tag_remain;
    logic [PW-1:0]           rd_nxt;
    logic [CH_W-1:0]         head_nxt;

    // First requesting channel strictly after the last granted one.
    always_comb begin
        pick_vld = 1'b0;
        pick_ch  = '0;
        cand     = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (!pick_vld && i_req_tvalid[cand]) begin
                pick_vld = 1'b1;
                pick_ch  = cand;
            end
        end
    end

    assign grant     = (state == S_IDLE) && pick_vld && (tag_cnt != FULL_CNT) && i_aclken;
    assign beat_last = (cnt == LAST_BEAT);
    assign beat_acc  = (state == S_DATA) && i_req_tvalid[gnt_ch] && i_fft_tready && i_aclken;
    // Early tlast and missing final tlast are both length errors; the frame length is fixed.
    assign len_err   = beat_acc && (beat_last ? !i_req_tlast[gnt_ch] : i_req_tlast[gnt_ch]);

    assign pop_req   = i_xk_tvalid && i_xk_tlast;
    assign pop_ok    = pop_req && (tag_cnt != '0);
    assign err_set   = i_aclken && (len_err || (pop_req && (tag_cnt == '0)));

    assign tag_cnt_nxt = tag_cnt + (PW+1)'(grant) - (PW+1)'(pop_ok);
    assign tag_remain  = tag_cnt - (PW+1)'(pop_ok);
    assign rd_nxt      = rd_ptr + PW'(pop_ok);

    // Registered head: when the only surviving entry is the one being pushed,
    // it is not in tag_mem yet, so take it straight from the arbiter.
    always_comb begin
        head_nxt = '0;
        if (tag_cnt_nxt == '0) begin
            head_nxt = '0;
        end else if (tag_remain == '0) begin
            head_nxt = pick_ch;
        end else begin
            head_nxt = tag_mem[rd_nxt];
        end
    end

    always_ff @(posedge i_clk or negedge srstn) begin
        if (!srstn) begin
            state <= S_IDLE;
        end else if (i_aclken) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        o_cfg_tvalid = 1'b0;
        o_cfg_tdata  = 1'b0;
        o_fft_tvalid = 1'b0;
        o_fft_tdata  = '0;
        o_fft_tlast  = 1'b0;
        o_req_tready = '0;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    state_nxt = S_CFG;
                end
            end
            S_CFG: begin
                o_cfg_tvalid = 1'b1;
                o_cfg_tdata  = gnt_dir;
                state_nxt    = S_DATA;
            end
            S_DATA: begin
                o_fft_tvalid         = i_req_tvalid[gnt_ch];
                o_fft_tdata          = i_req_tdata[int'(gnt_ch)*DW +: DW];
                o_fft_tlast          = i_req_tlast[gnt_ch] || beat_last;
                o_req_tready[gnt_ch] = i_fft_tready;
                if (beat_acc && beat_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge srstn) begin
        if (!srstn) begin
            gnt_ch  <= '0;
            gnt_dir <= 1'b0;
            rr_ptr  <= CH_W'(NUM_CH - 1);
            cnt     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
            xk_ch_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < MAX_OUT; i++) begin
                tag_mem[i] <= '0;
            end
        end else if (i_aclken) begin
            if (grant) begin
                gnt_ch          <= pick_ch;
                gnt_dir         <= i_req_dir[pick_ch];
                rr_ptr          <= pick_ch;
                tag_mem[wr_ptr] <= pick_ch;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (beat_acc) begin
                cnt <= beat_last ? '0 : cnt + LOG2_FFT_LEN'(1);
            end
            rd_ptr  <= rd_nxt;
            tag_cnt <= tag_cnt_nxt;
            xk_ch_q <= head_nxt;
            if (err_set) begin
                err_q <= 1'b1;
            end else if (i_err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign o_xk_ch   = xk_ch_q;
    assign o_frm_err = err_q;
    assign o_busy    = (state != S_IDLE) || (tag_cnt != '0);

endmodule
